// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    // Read data returned to a requester whose operation was abandoned by the watchdog.
    localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;

    // One-hot acknowledge vector for the requester that owns the port.
    function automatic logic [1:0] ack_vector(input logic who);
        return who ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request wins outright, contention goes
// to the pointer, and the pointer moves away from every granted requester.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] p,
    input  logic       update,
    output logic       grant,
    output logic       grant_valid
);

    logic rr;

    // Pick the winner from the current pending set and the fairness pointer.
    always_comb begin
        grant_valid = p[0] | p[1];
        if (p[0] && p[1]) begin
            grant = rr;
        end else begin
            grant = p[1];
        end
    end

    // After a grant the other requester is favoured at the next contention.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr <= 1'b0;
        end else if (update) begin
            rr <= ~grant;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port (write channel mem_in_*, read channel mem_out_*)
// between two requesters, one operation in flight at a time, with a
// watchdog that frees the port if memory never answers.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int TIMER_WIDTH    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_wr,
    input  logic [1:0]       req_rd,
    input  logic [1:0][31:0] req_addr,
    input  logic [1:0][31:0] req_wdata,
    output logic [1:0]       req_ack,
    output logic [31:0]      req_rdata,
    output logic [31:0]      mem_in_addr,
    output logic [31:0]      mem_in_data,
    output logic             mem_in_valid,
    input  logic             mem_in_ready,
    output logic [31:0]      mem_out_addr,
    output logic             mem_out_valid,
    input  logic [31:0]      mem_out_data,
    input  logic             mem_out_ready,
    output logic             owner,
    output logic             busy,
    output logic             timeout_error
);

    arb_state_t  state;
    arb_state_t  state_next;
    logic [1:0]  pending;
    logic        grant;
    logic        grant_valid;
    logic        take;
    logic        in_mem;
    logic        expired;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    assign pending = req_wr | req_rd;
    assign take    = (state == IDLE) && grant_valid;
    assign in_mem  = (state == WRITE) || (state == READ);

    rr_arbiter2 u_rr (
        .clk         (clk),
        .reset       (reset),
        .p           (pending),
        .update      (take),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Watchdog: counts cycles spent waiting on memory; absent when disabled.
    generate
        if (TIMEOUT_CYCLES > 0) begin : g_watchdog
            localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
            logic [TIMER_WIDTH-1:0] timer;

            // Restart on every entry into a memory wait; hold at zero otherwise.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    timer <= '0;
                end else if (in_mem) begin
                    timer <= timer + 1'b1;
                end else begin
                    timer <= '0;
                end
            end

            assign expired = in_mem && (timer == TIMER_LAST);
        end else begin : g_no_watchdog
            assign expired = 1'b0;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: grant from IDLE, wait for the memory handshake or watchdog, ack once.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = req_wr[grant] ? WRITE : READ;
            WRITE:   if (mem_in_ready || expired) state_next = DONE;
            READ:    if (mem_out_ready || expired) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes and acknowledge are a Moore decode of the state register.
    always_comb begin
        mem_in_valid  = (state == WRITE);
        mem_out_valid = (state == READ);
        mem_in_addr   = addr_q;
        mem_in_data   = wdata_q;
        mem_out_addr  = addr_q;
        req_ack       = (state == DONE) ? ack_vector(owner) : 2'b00;
    end

    // Latch the granted request, capture read data, and record watchdog expiry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q        <= '0;
            wdata_q       <= '0;
            owner         <= 1'b0;
            busy          <= 1'b0;
            req_rdata     <= '0;
            timeout_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        addr_q  <= req_addr[grant];
                        wdata_q <= req_wdata[grant];
                        owner   <= grant;
                        busy    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (!mem_in_ready && expired) begin
                        req_rdata     <= TIMEOUT_DATA;
                        timeout_error <= 1'b1;
                    end
                end
                READ: begin
                    if (mem_out_ready) begin
                        req_rdata <= mem_out_data;
                    end else if (expired) begin
                        req_rdata     <= TIMEOUT_DATA;
                        timeout_error <= 1'b1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
